// File: rtl/proc_pkg.sv
// Shared definitions for the processor operand-fetch path.
// Contents:
//   ADDR_W   - register address width (8 registers)
//   op1_e    - major opcode field encodings
//   state_e  - operand-fetch FSM states
package proc_pkg;

  localparam int unsigned ADDR_W = 3;

  typedef enum logic [1:0] {
    OP1_LOAD  = 2'd0,
    OP1_STORE = 2'd1,
    OP1_IMM   = 2'd2,
    OP1_ALU   = 2'd3
  } op1_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAddr  = 2'd1,
    StRead  = 2'd2,
    StValid = 2'd3
  } state_e;

endpackage

// File: rtl/src_decode.sv
// Source-operand decode, purely combinational.
// Ports:
//   op1           - major opcode field
//   rd_rb, ra_op2 - register fields of the instruction
//   addr_a/addr_b - register-file read addresses for ports A and B
//   use_a/use_b   - port carries a meaningful operand
module src_decode #(
  parameter int unsigned ADDR_W = 3
) (
  input  logic [1:0]        op1,
  input  logic [ADDR_W-1:0] rd_rb,
  input  logic [ADDR_W-1:0] ra_op2,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              use_a,
  output logic              use_b
);
  import proc_pkg::*;

  // Port B always reads Rd_Rb (base or destination); port A is only
  // needed when the instruction has a second register source.
  always_comb begin
    addr_b = rd_rb;
    use_b  = 1'b1;
    addr_a = '0;
    use_a  = 1'b0;
    case (op1)
      OP1_STORE, OP1_ALU: begin
        addr_a = ra_op2;
        use_a  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/read_address.sv
// Operand fetch for the register-file read side.
// Decodes instruction fields into two read addresses, captures the read data
// (forwarding a same-cycle write-back) and presents the operand pair to the
// execute stage through a valid/ack handshake.
// Ports:
//   clock, reset_n                 - clock, async active-low reset
//   start, op1, Rd_Rb, Ra_op2      - fetch request and instruction fields
//   rf_read_add_a/b, rf_data_a/b   - register-file read port
//   wb_en, write_add, wb_data      - write-back port (commits at same edge)
//   operand_a/b, use_a/b, valid    - held operand pair to consumer
//   ack                            - consumer accepts operands
//   busy                           - fetch in progress (ADDR/READ)
module read_address #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op1,
  input  logic [ADDR_W-1:0] Rd_Rb,
  input  logic [ADDR_W-1:0] Ra_op2,
  output logic [ADDR_W-1:0] rf_read_add_a,
  output logic [ADDR_W-1:0] rf_read_add_b,
  input  logic [WIDTH-1:0]  rf_data_a,
  input  logic [WIDTH-1:0]  rf_data_b,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] write_add,
  input  logic [WIDTH-1:0]  wb_data,
  output logic [WIDTH-1:0]  operand_a,
  output logic [WIDTH-1:0]  operand_b,
  output logic              use_a,
  output logic              use_b,
  output logic              valid,
  input  logic              ack,
  output logic              busy
);
  import proc_pkg::*;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_a_q, addr_b_q, dec_addr_a, dec_addr_b;
  logic              use_a_q, use_b_q, dec_use_a, dec_use_b;
  logic [WIDTH-1:0]  operand_a_q, operand_b_q, operand_a_d, operand_b_d;
  logic              accept, capture;
  logic              fwd_a, fwd_b;

  src_decode #(
    .ADDR_W (ADDR_W)
  ) u_src_decode (
    .op1    (op1),
    .rd_rb  (Rd_Rb),
    .ra_op2 (Ra_op2),
    .addr_a (dec_addr_a),
    .addr_b (dec_addr_b),
    .use_a  (dec_use_a),
    .use_b  (dec_use_b)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StAddr;
      StAddr:  state_d = StRead;
      StRead:  state_d = StValid;
      StValid: if (ack) state_d = start ? StAddr : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    valid   = (state_q == StValid);
    busy    = (state_q == StAddr) || (state_q == StRead);
    capture = (state_q == StRead);
    // A start in VALID only counts when the current pair is being consumed.
    accept  = start && ((state_q == StIdle) || ((state_q == StValid) && ack));
  end

  // The write lands in the register file at the capture edge, so the read
  // data is stale for that register; take the write data instead.
  always_comb begin
    fwd_a       = wb_en && (write_add == addr_a_q) && use_a_q;
    fwd_b       = wb_en && (write_add == addr_b_q) && use_b_q;
    operand_a_d = !use_a_q ? '0 : (fwd_a ? wb_data : rf_data_a);
    operand_b_d = !use_b_q ? '0 : (fwd_b ? wb_data : rf_data_b);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      use_a_q     <= 1'b0;
      use_b_q     <= 1'b0;
      operand_a_q <= '0;
      operand_b_q <= '0;
    end else begin
      if (accept) begin
        addr_a_q <= dec_addr_a;
        addr_b_q <= dec_addr_b;
        use_a_q  <= dec_use_a;
        use_b_q  <= dec_use_b;
      end
      if (capture) begin
        operand_a_q <= operand_a_d;
        operand_b_q <= operand_b_d;
      end
    end
  end

  assign rf_read_add_a = addr_a_q;
  assign rf_read_add_b = addr_b_q;
  assign use_a         = use_a_q;
  assign use_b         = use_b_q;
  assign operand_a     = operand_a_q;
  assign operand_b     = operand_b_q;

endmodule
